logic_gates_acc: RTL and testbench

LOGIC_GATES_ACC -- requirements
Module: logic_gates_acc

---
 rtl/logic_gates_acc_if.sv | 29 ++
 rtl/logic_gates_acc.sv | 196 +++++++++++++++++++
 tb/tb_logic_gates_acc.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/logic_gates_acc_if.sv
// Operand/result bus for logic_gates_acc. Adds oPop when LOGIC_GATES_ACC_POPCNT_EN is defined.
interface logic_gates_acc_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             iValid;
  logic [WIDTH-1:0] iA;
  logic [WIDTH-1:0] iB;
  logic [2:0]       iOp;
  logic             iAcc;
  logic             iLast;
  logic             oValid;
  logic [WIDTH-1:0] oY;
  logic             oDone;
  logic [CNT_W-1:0] oCount;
`ifdef LOGIC_GATES_ACC_POPCNT_EN
  logic [$clog2(WIDTH+1)-1:0] oPop;

  modport master (output iValid, iA, iB, iOp, iAcc, iLast,
                  input  oValid, oY, oDone, oCount, oPop);
  modport slave  (input  iValid, iA, iB, iOp, iAcc, iLast,
                  output oValid, oY, oDone, oCount, oPop);
`else
  modport master (output iValid, iA, iB, iOp, iAcc, iLast,
                  input  oValid, oY, oDone, oCount);
  modport slave  (input  iValid, iA, iB, iOp, iAcc, iLast,
                  output oValid, oY, oDone, oCount);
`endif
endinterface

// File: rtl/logic_gates_acc.sv
// Bitwise logic unit with direct and multi-beat accumulate modes and a saturating result counter.
// Optional popcount output enabled by defining LOGIC_GATES_ACC_POPCNT_EN.
module logic_gates_acc #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             iClk,
  input  logic             iRst,
  logic_gates_acc_if.slave bus
);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_NOT  = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_NAND = 3'b100;
  localparam logic [2:0] OP_NOR  = 3'b101;
  localparam logic [2:0] OP_XNOR = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  typedef enum logic [0:0] {IDLE = 1'b0, ACC = 1'b1} stateE;

  function automatic logic [WIDTH-1:0] directOp(input logic [2:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    case (op)
      OP_AND:  directOp = a & b;
      OP_OR:   directOp = a | b;
      OP_NOT:  directOp = ~a;
      OP_XOR:  directOp = a ^ b;
      OP_NAND: directOp = ~(a & b);
      OP_NOR:  directOp = ~(a | b);
      OP_XNOR: directOp = ~(a ^ b);
      default: directOp = a;
    endcase
  endfunction

  // Inverting ops accumulate with their base op; inversion happens only on the way out.
  function automatic logic [WIDTH-1:0] accStep(input logic [2:0] op,
                                               input logic [WIDTH-1:0] acc,
                                               input logic [WIDTH-1:0] a);
    case (op)
      OP_AND, OP_NAND: accStep = acc & a;
      OP_OR,  OP_NOR:  accStep = acc | a;
      OP_XOR, OP_XNOR: accStep = acc ^ a;
      OP_NOT:          accStep = ~a;
      default:         accStep = a;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] finalize(input logic [2:0] op,
                                                input logic [WIDTH-1:0] v);
    case (op)
      OP_NAND, OP_NOR, OP_XNOR: finalize = ~v;
      default:                  finalize = v;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] loadVal(input logic [2:0] op,
                                               input logic [WIDTH-1:0] a);
    if (op == OP_NOT) begin
      loadVal = ~a;
    end else begin
      loadVal = a;
    end
  endfunction

`ifdef LOGIC_GATES_ACC_POPCNT_EN
  localparam int PW = $clog2(WIDTH+1);

  function automatic logic [PW-1:0] popCount(input logic [WIDTH-1:0] v);
    popCount = {PW{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      popCount = popCount + PW'(v[i]);
    end
  endfunction

  logic [PW-1:0] popR;
`endif

  stateE            stateR;
  logic [2:0]       opR;
  logic [WIDTH-1:0] accR;
  logic [WIDTH-1:0] yR;
  logic             validR;
  logic             doneR;
  logic [CNT_W-1:0] countR;

  logic [WIDTH-1:0] loadS;
  logic [WIDTH-1:0] stepS;
  logic [WIDTH-1:0] resultS;
  logic             emitS;
  logic             doneS;
  logic [CNT_W-1:0] countNextS;

  // Decide whether this cycle produces a result and what it is.
  always_comb begin
    loadS   = loadVal(bus.iOp, bus.iA);
    stepS   = accStep(opR, accR, bus.iA);
    emitS   = 1'b0;
    doneS   = 1'b0;
    resultS = yR;
    case (stateR)
      IDLE: begin
        if (bus.iValid) begin
          if (!bus.iAcc) begin
            emitS   = 1'b1;
            resultS = directOp(bus.iOp, bus.iA, bus.iB);
          end else if (bus.iLast) begin
            emitS   = 1'b1;
            doneS   = 1'b1;
            resultS = finalize(bus.iOp, loadS);
          end else begin
            emitS = 1'b0;
          end
        end else begin
          emitS = 1'b0;
        end
      end
      ACC: begin
        if (bus.iValid && bus.iLast) begin
          emitS   = 1'b1;
          doneS   = 1'b1;
          resultS = finalize(opR, stepS);
        end else begin
          emitS = 1'b0;
        end
      end
      default: begin
        emitS = 1'b0;
      end
    endcase
    if (countR == {CNT_W{1'b1}}) begin
      countNextS = countR;
    end else begin
      countNextS = countR + CNT_W'(1);
    end
  end

  // FSM, accumulator and registered result outputs.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      stateR <= IDLE;
      opR    <= 3'b000;
      accR   <= {WIDTH{1'b0}};
      yR     <= {WIDTH{1'b0}};
      validR <= 1'b0;
      doneR  <= 1'b0;
      countR <= {CNT_W{1'b0}};
`ifdef LOGIC_GATES_ACC_POPCNT_EN
      popR   <= {PW{1'b0}};
`endif
    end else begin
      validR <= emitS;
      doneR  <= doneS;
      if (emitS) begin
        yR     <= resultS;
        countR <= countNextS;
`ifdef LOGIC_GATES_ACC_POPCNT_EN
        popR   <= popCount(resultS);
`endif
      end
      case (stateR)
        IDLE: begin
          if (bus.iValid && bus.iAcc) begin
            opR  <= bus.iOp;
            accR <= loadS;
            if (!bus.iLast) begin
              stateR <= ACC;
            end
          end
        end
        ACC: begin
          if (bus.iValid) begin
            accR <= stepS;
            if (bus.iLast) begin
              stateR <= IDLE;
            end
          end
        end
        default: begin
          stateR <= IDLE;
        end
      endcase
    end
  end

  assign bus.oValid = validR;
  assign bus.oY     = yR;
  assign bus.oDone  = doneR;
  assign bus.oCount = countR;
`ifdef LOGIC_GATES_ACC_POPCNT_EN
  assign bus.oPop   = popR;
`endif

endmodule

// File: tb/tb_logic_gates_acc.sv
// Self-checking bench for logic_gates_acc: vector table, hand sequences and a random run vs. a per-bit reference model.
module tb_logic_gates_acc;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic_gates_acc_if #(.WIDTH(8), .CNT_W(8)) bus ();
  logic_gates_acc_if #(.WIDTH(8), .CNT_W(2)) bus2 ();

  logic_gates_acc #(.WIDTH(8), .CNT_W(8)) dut  (.iClk(clk), .iRst(rst), .bus(bus));
  logic_gates_acc #(.WIDTH(8), .CNT_W(2)) dut2 (.iClk(clk), .iRst(rst), .bus(bus2));

  int passCnt = 0;
  int totalCnt = 0;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] y;
  } dirVecT;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic acc, input logic last,
                       input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    bus.iValid = v; bus.iAcc = acc; bus.iLast = last;
    bus.iOp = op; bus.iA = a; bus.iB = b;
  endtask

  task automatic chkOut(input string name, input logic v, input logic d,
                        input logic [7:0] y, input int cnt);
    chk({name, ".valid"}, 32'(bus.oValid), 32'(v));
    chk({name, ".done"},  32'(bus.oDone),  32'(d));
    chk({name, ".y"},     32'(bus.oY),     32'(y));
    chk({name, ".count"}, 32'(bus.oCount), 32'(cnt));
`ifdef LOGIC_GATES_ACC_POPCNT_EN
    chk({name, ".pop"},   32'(bus.oPop),   32'($countones(y)));
`endif
  endtask

  // Per-bit rule: AND = every beat has a 1, OR = some beat has a 1, XOR = odd number of 1s.
  function automatic logic [7:0] refStream(input logic [2:0] op, input logic [7:0] beats[$]);
    logic [7:0] r;
    int ones;
    if (op == 3'd2) return ~beats[beats.size()-1];
    if (op == 3'd7) return beats[beats.size()-1];
    for (int k = 0; k < 8; k++) begin
      ones = 0;
      foreach (beats[j]) ones += int'(beats[j][k]);
      case (op)
        3'd0, 3'd4: r[k] = (ones == beats.size());
        3'd1, 3'd5: r[k] = (ones > 0);
        default:    r[k] = (ones % 2 == 1);
      endcase
    end
    if (op >= 3'd4) r = ~r;
    return r;
  endfunction

  function automatic logic [7:0] refDirect(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] pair[$];
    pair = {a, b};
    if (op == 3'd2) return ~a;
    if (op == 3'd7) return a;
    return refStream(op, pair);
  endfunction

  dirVecT dirTab[8];
  int cnt2Exp[5] = '{1, 2, 3, 3, 3};

  initial begin
    logic [7:0] q[$];
    logic inAcc;
    logic [2:0] mOp;
    logic [7:0] lastY;
    logic [7:0] expY;
    logic expV, expD;
    logic v, acc, last;
    logic [2:0] op;
    logic [7:0] a, b;
    int cnt;

    dirTab[0] = '{3'd0, 8'hF0, 8'h3C, 8'h30};
    dirTab[1] = '{3'd5, 8'h0F, 8'hF0, 8'h00};
    dirTab[2] = '{3'd6, 8'hAA, 8'hAA, 8'hFF};
    dirTab[3] = '{3'd1, 8'hA0, 8'h05, 8'hA5};
    dirTab[4] = '{3'd2, 8'h3C, 8'hFF, 8'hC3};
    dirTab[5] = '{3'd3, 8'hFF, 8'h0F, 8'hF0};
    dirTab[6] = '{3'd4, 8'hF0, 8'h3C, 8'hCF};
    dirTab[7] = '{3'd7, 8'h5A, 8'h00, 8'h5A};

    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
    bus2.iValid = 1'b0; bus2.iAcc = 1'b0; bus2.iLast = 1'b0;
    bus2.iOp = 3'd0; bus2.iA = 8'h00; bus2.iB = 8'h00;
    #3;
    chkOut("reset", 1'b0, 1'b0, 8'h00, 0);
    step();
    rst = 1'b0;
    step();
    chkOut("postreset", 1'b0, 1'b0, 8'h00, 0);

    // Back-to-back direct operations, one result per cycle.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 1'b0, dirTab[i].op, dirTab[i].a, dirTab[i].b);
      step();
      chkOut($sformatf("direct%0d", i), 1'b1, 1'b0, dirTab[i].y, i + 1);
    end
    drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
    step();
    chkOut("idlehold", 1'b0, 1'b0, 8'h5A, 8);

    // Asynchronous reset between clock edges.
    drive(1'b1, 1'b0, 1'b0, 3'd0, 8'hFF, 8'hFF);
    step();
    drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
    chkOut("prereset", 1'b1, 1'b0, 8'hFF, 9);
    #2 rst = 1'b1;
    #1;
    chkOut("asyncreset", 1'b0, 1'b0, 8'h00, 0);
    #1 rst = 1'b0;
    step();

    // XOR stream with a gap, iLast on the gap beat must be ignored.
    drive(1'b1, 1'b1, 1'b0, 3'd3, 8'h01, 8'hFF); step();
    chk("xor.b1.valid", 32'(bus.oValid), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 3'd0, 8'h02, 8'h00); step();
    chk("xor.b2.valid", 32'(bus.oValid), 32'd0);
    drive(1'b0, 1'b0, 1'b1, 3'd0, 8'h80, 8'h00); step();
    chk("xor.gap.valid", 32'(bus.oValid), 32'd0);
    drive(1'b1, 1'b0, 1'b1, 3'd1, 8'h04, 8'h00); step();
    chkOut("xor.end", 1'b1, 1'b1, 8'h07, 1);
    drive(1'b1, 1'b0, 1'b0, 3'd0, 8'hF0, 8'h3C); step();
    chkOut("xor.thenidle", 1'b1, 1'b0, 8'h30, 2);
    drive(1'b0, 1'b1, 1'b1, 3'd0, 8'h11, 8'h00); step();
    chk("idle.lastnovalid", 32'(bus.oValid), 32'd0);

    // NAND stream and single-beat NOT stream.
    drive(1'b1, 1'b1, 1'b0, 3'd4, 8'hFF, 8'h00); step();
    chk("nand.b1.valid", 32'(bus.oValid), 32'd0);
    drive(1'b1, 1'b1, 1'b1, 3'd1, 8'h0F, 8'h00); step();
    chkOut("nand.end", 1'b1, 1'b1, 8'hF0, 3);
    drive(1'b1, 1'b1, 1'b1, 3'd2, 8'h5A, 8'h00); step();
    chkOut("not.single", 1'b1, 1'b1, 8'hA5, 4);

    // Reset during a stream drops the partial result.
    drive(1'b1, 1'b1, 1'b0, 3'd0, 8'hFF, 8'h00); step();
    drive(1'b1, 1'b0, 1'b0, 3'd0, 8'h0F, 8'h00); step();
    drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midreset.valid", 32'(bus.oValid), 32'd0);
    step();
    chk("midreset.valid2", 32'(bus.oValid), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 3'd1, 8'h01, 8'h80); step();
    chkOut("midreset.or", 1'b1, 1'b0, 8'h81, 1);
    drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00);

    // Narrow counter saturates at 3.
    for (int i = 0; i < 5; i++) begin
      bus2.iValid = 1'b1; bus2.iAcc = 1'b0; bus2.iOp = 3'd3;
      bus2.iA = 8'(i); bus2.iB = 8'h07;
      step();
      chk($sformatf("cnt2.%0d", i), 32'(bus2.oCount), 32'(cnt2Exp[i]));
    end
    bus2.iValid = 1'b0;
    step();
    chkOut("cnt2.idle", 1'b0, 1'b0, 8'h81, 1);

    // Random run against the reference model; long enough to saturate the 8-bit counter.
    inAcc = 1'b0; mOp = 3'd0; lastY = 8'h81; cnt = 1;
    for (int n = 0; n < 800; n++) begin
      v = ($urandom_range(0, 3) != 0);
      acc = 1'($urandom_range(0, 1));
      last = ($urandom_range(0, 3) == 0);
      op = 3'($urandom_range(0, 7));
      a = 8'($urandom);
      b = 8'($urandom);
      expV = 1'b0; expD = 1'b0; expY = lastY;
      if (v) begin
        if (!inAcc) begin
          if (!acc) begin
            expV = 1'b1;
            expY = refDirect(op, a, b);
          end else begin
            q = {a};
            mOp = op;
            if (last) begin
              expV = 1'b1; expD = 1'b1; expY = refStream(mOp, q);
            end else begin
              inAcc = 1'b1;
            end
          end
        end else begin
          q.push_back(a);
          if (last) begin
            expV = 1'b1; expD = 1'b1; expY = refStream(mOp, q);
            inAcc = 1'b0;
          end
        end
      end
      if (expV) begin
        lastY = expY;
        cnt++;
      end
      drive(v, acc, last, op, a, b);
      step();
      chkOut($sformatf("rand%0d", n), expV, expD, lastY, (cnt > 255) ? 255 : cnt);
    end

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
